center_tx: RTL
==============

CENTER_TX -- requirements
Module: center_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter HEADER, default 8'hA5, first byte of every frame.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid  input  1  center sample valid; driven by the upstream gravity_center ready output.
REQ-006 SHALL have port Xc  input  8  center x coordinate, sampled when accepted.
REQ-007 SHALL have port Yc  input  8  center y coordinate, sampled when accepted.
REQ-008 SHALL have port tx  output  1  serial line, idle high, 8N1, LSB first.
REQ-009 SHALL have port busy  output  1  frame in progress.
REQ-010 SHALL have port dropped  output  8  saturating count of valid cycles not accepted.

Function
REQ-011 SHALL accept a sample on any cycle with valid=1 and busy=0; Xc and Yc are captured into internal registers on that edge.
REQ-012 SHALL assert busy on the cycle after acceptance and hold it through the final stop bit of the frame.
REQ-013 SHALL transmit frame bytes in order: HEADER, Xc, Yc, then the checksum byte only when CENTER_TX_CHECKSUM_EN is defined.
REQ-014 SHALL encode each byte as a start bit (0), 8 data bits LSB first, and a stop bit (1); each bit lasts exactly CLKS_PER_BIT cycles.
REQ-015 SHALL drive the start bit of HEADER on the cycle after acceptance, giving 1-cycle latency from accept to tx falling.
REQ-016 SHALL send bytes back-to-back with no idle gap between one stop bit and the next start bit.
REQ-017 SHALL use the FSM states IDLE -> START -> DATA (8 bits) -> STOP, then START if bytes remain, else IDLE.
REQ-018 SHALL count bits with a 3-bit index, bytes with a 2-bit index, and clocks with a bit-period counter that wraps at CLKS_PER_BIT-1.
REQ-019 SHALL allow a new sample to be accepted on the first cycle busy is low after a frame; no dead cycle is required.
REQ-020 SHALL increment dropped on each cycle with valid=1 and busy=1, saturating at 255 with no wrap.
REQ-021 SHALL ignore changes on Xc and Yc during a frame; the transmitted values are the ones captured at acceptance.

Reset
REQ-022 SHALL respond to rst=1 at the next edge: FSM to IDLE, tx=1, busy=0, dropped=0, and all counters and indices cleared.
REQ-023 SHALL abort any frame in progress when rst asserts mid-frame, with tx returning high on the next edge and no remaining bits sent.
REQ-024 SHALL give rst priority over a simultaneous valid; no sample is accepted on that edge.

Configuration
REQ-025 SHALL append a fourth checksum byte equal to HEADER^Xc^Yc when CENTER_TX_CHECKSUM_EN is defined, giving a frame of 40*CLKS_PER_BIT cycles.
REQ-026 SHALL send only 3 bytes when CENTER_TX_CHECKSUM_EN is undefined, giving a frame of 30*CLKS_PER_BIT cycles, and SHALL contain no checksum logic.

Verification
REQ-027 SHALL verify single frame: CLKS_PER_BIT=4, valid pulse with Xc=0x12, Yc=0x34 -> decoded bytes A5,12,34,83 with macro (160 busy cycles), or A5,12,34 without it (120 busy cycles).
REQ-028 SHALL verify continuous valid: valid held high for 400 cycles with CLKS_PER_BIT=4 and macro defined -> frames back-to-back, one idle cycle between frames, dropped increments every busy cycle and saturates at 255.
REQ-029 SHALL verify data hold: Xc changes from 0x12 to 0xFF mid-frame -> frame still carries 0x12.
REQ-030 SHALL verify reset mid-frame: rst pulsed during the Xc data bits -> tx=1, busy=0, dropped=0 next cycle, and the next valid starts a clean HEADER frame.
REQ-031 SHALL verify reset/valid collision: rst=1 and valid=1 on the same edge -> no frame starts and tx stays high.
REQ-032 SHALL verify bit timing: CLKS_PER_BIT=2 -> each tx bit held exactly 2 cycles, with start-bit latency of 1 cycle after the accepting edge.

Source files
------------

// File: rtl/center_tx.sv
// center_tx: frames a (Xc, Yc) centre sample as HEADER, Xc, Yc [, checksum] on an 8N1 serial line.
// Define CENTER_TX_CHECKSUM_EN to append a fourth byte, HEADER ^ Xc ^ Yc.
module center_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [7:0]  HEADER       = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  logic [7:0] Xc,
  input  logic [7:0] Yc,
  output logic       tx,
  output logic       busy,
  output logic [7:0] dropped
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [7:0] CNT_MAX = 8'(CLKS_PER_BIT - 1);
`ifdef CENTER_TX_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  state_t     state;
  logic [7:0] clk_cnt;
  logic [2:0] bit_idx;
  logic [1:0] byte_idx;
  logic [7:0] x_reg;
  logic [7:0] y_reg;
  logic [7:0] cur_byte;

  always_comb begin
    cur_byte = HEADER;
    case (byte_idx)
      2'd0:    cur_byte = HEADER;
      2'd1:    cur_byte = x_reg;
      2'd2:    cur_byte = y_reg;
`ifdef CENTER_TX_CHECKSUM_EN
      default: cur_byte = HEADER ^ x_reg ^ y_reg;
`else
      default: cur_byte = HEADER;
`endif
    endcase
  end

  // tx is loaded one bit ahead, so each bit appears on the edge that starts its period.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      dropped  <= 8'd0;
      clk_cnt  <= 8'd0;
      bit_idx  <= 3'd0;
      byte_idx <= 2'd0;
      x_reg    <= 8'd0;
      y_reg    <= 8'd0;
    end else begin
      if (valid && busy && dropped != 8'hFF)
        dropped <= dropped + 8'd1;

      case (state)
        IDLE: begin
          clk_cnt  <= 8'd0;
          bit_idx  <= 3'd0;
          byte_idx <= 2'd0;
          if (valid) begin
            x_reg <= Xc;
            y_reg <= Yc;
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= START;
          end
        end
        START: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= 8'd0;
            bit_idx <= 3'd0;
            tx      <= cur_byte[0];
            state   <= DATA;
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= 8'd0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_MAX) begin
            clk_cnt <= 8'd0;
            if (byte_idx == LAST_BYTE) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            clk_cnt <= clk_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
